// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Access type codes, size decode, FSM states and load extension
//            shared by the byte-wide memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // lsb_type: bit3 store, bit2 unsigned, [1:0] size
    localparam logic [3:0] c_LB  = 4'b0000;
    localparam logic [3:0] c_LH  = 4'b0001;
    localparam logic [3:0] c_LW  = 4'b0010;
    localparam logic [3:0] c_LBU = 4'b0100;
    localparam logic [3:0] c_LHU = 4'b0101;
    localparam logic [3:0] c_SB  = 4'b1000;
    localparam logic [3:0] c_SH  = 4'b1001;
    localparam logic [3:0] c_SW  = 4'b1010;

    localparam logic [1:0] c_SIZE_B  = 2'b00;
    localparam logic [1:0] c_SIZE_H  = 2'b01;
    localparam logic [1:0] c_SIZE_W  = 2'b10;

    localparam logic [1:0] c_IO_MASK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IFETCH = 2'd1,
        S_LOAD   = 2'd2,
        S_STORE  = 2'd3
    } state_t;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            c_SIZE_B: return 3'd1;
            c_SIZE_H: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic        is_unsigned,
                                                input logic [1:0]  size);
        case (size)
            c_SIZE_B: return is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            c_SIZE_H: return is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one byte-wide RAM port between instruction fetch and the
//            load/store buffer; optional IO store stall via MEM_IO_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] IO_MASK = c_IO_MASK
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_finished,
    output logic [31:0]       if_inst,
    input  logic              ls_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_val,
    input  logic [3:0]        lsb_type,
    output logic              ls_finished,
    output logic [31:0]       load_val,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [31:0]       r_store;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;
    logic              r_ls_fin;
    logic              r_if_fin;
    logic [31:0]       r_load_val;
    logic [31:0]       r_if_inst;
    logic              r_store_clr;

    logic              w_stall;
    logic [1:0]        w_idx;
    logic [2:0]        w_cnt_nx;
    logic [ADDR_W-1:0] w_next_a;
    logic [31:0]       w_asm;

`ifdef MEM_IO_STALL_EN
    assign w_stall = (r_state == S_STORE) && (r_base[17:16] == IO_MASK) && io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full;
    assign w_stall     = 1'b0;
`endif

    // The byte on mem_din belongs to the address issued one cycle earlier.
    assign w_idx    = r_cnt[1:0] - 2'd1;
    assign w_cnt_nx = r_cnt + 3'd1;
    assign w_next_a = r_base + {{(ADDR_W-3){1'b0}}, w_cnt_nx};

    always_comb begin
        w_asm             = r_buf;
        w_asm[8*w_idx +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_store     <= '0;
            r_buf       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_ls_fin    <= 1'b0;
            r_if_fin    <= 1'b0;
            r_load_val  <= '0;
            r_if_inst   <= '0;
            r_store_clr <= 1'b0;
        end else if (rdy_in) begin
            r_ls_fin <= 1'b0;
            r_if_fin <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!clear && (ls_enable || if_enable)) begin
                        r_cnt       <= '0;
                        r_buf       <= '0;
                        r_store_clr <= 1'b0;
                        if (ls_enable) begin
                            r_base  <= addr;
                            r_mem_a <= addr;
                            r_size  <= lsb_type[1:0];
                            r_uns   <= lsb_type[2];
                            r_store <= store_val;
                            r_len   <= size_len(lsb_type[1:0]);
                            if (lsb_type[3]) begin
                                r_state    <= S_STORE;
                                r_mem_wr   <= 1'b1;
                                r_mem_dout <= store_val[7:0];
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end else begin
                            r_base  <= if_addr;
                            r_mem_a <= if_addr;
                            r_len   <= 3'd4;
                            r_state <= S_IFETCH;
                        end
                    end
                end
                S_IFETCH, S_LOAD: begin
                    if (clear) begin
                        r_state <= S_IDLE;
                        r_mem_a <= '0;
                    end else begin
                        if (r_cnt != 3'd0)
                            r_buf <= w_asm;
                        if (r_cnt == r_len) begin
                            r_state <= S_IDLE;
                            r_mem_a <= '0;
                            if (r_state == S_LOAD) begin
                                r_load_val <= extend_load(w_asm, r_uns, r_size);
                                r_ls_fin   <= 1'b1;
                            end else begin
                                r_if_inst <= w_asm;
                                r_if_fin  <= 1'b1;
                            end
                        end else begin
                            r_cnt   <= w_cnt_nx;
                            r_mem_a <= (w_cnt_nx < r_len) ? w_next_a : '0;
                        end
                    end
                end
                S_STORE: begin
                    // A flushed store still drains; only its completion pulse is dropped.
                    if (clear)
                        r_store_clr <= 1'b1;
                    if (!w_stall) begin
                        if (w_cnt_nx == r_len) begin
                            r_state    <= S_IDLE;
                            r_mem_a    <= '0;
                            r_mem_wr   <= 1'b0;
                            r_mem_dout <= '0;
                            if (!(r_store_clr || clear)) begin
                                r_ls_fin   <= 1'b1;
                                r_load_val <= '0;
                            end
                        end else begin
                            r_cnt      <= w_cnt_nx;
                            r_mem_a    <= w_next_a;
                            r_mem_dout <= r_store[8*w_cnt_nx[1:0] +: 8];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mem_a <= '0;
                end
            endcase
        end
    end

    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_wr      = r_mem_wr && rdy_in && !w_stall;
    assign ls_finished = r_ls_fin;
    assign if_finished = r_if_fin;
    assign load_val    = r_load_val;
    assign if_inst     = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
    localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, if_enable, ls_enable, io_buffer_full;
    logic [31:0] if_addr, addr, store_val, if_inst, load_val, mem_a;
    logic [3:0]  lsb_type;
    logic [7:0]  mem_din, mem_dout;
    logic        if_finished, ls_finished, mem_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_W(32), .IO_MASK(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_enable(if_enable), .if_addr(if_addr), .if_finished(if_finished), .if_inst(if_inst),
        .ls_enable(ls_enable), .addr(addr), .store_val(store_val), .lsb_type(lsb_type),
        .ls_finished(ls_finished), .load_val(load_val), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    // 64 KiB RAM image (upper address bits alias), seeded by a fixed pattern until written
    logic [7:0] ram [0:65535];
    logic       wv  [0:65535];

    function automatic logic [7:0] seed(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h78;
            16'h1001: return 8'h56;
            16'h1002: return 8'h34;
            16'h1003: return 8'h12;
            16'h0020: return 8'h80;
            16'hFFFE: return 8'h11;
            16'hFFFF: return 8'h22;
            16'h0000: return 8'h33;
            16'h0001: return 8'h44;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        return wv[a[15:0]] ? ram[a[15:0]] : seed(a[15:0]);
    endfunction

    always @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 65536; i++) wv[i] <= 1'b0;
        end else if (mem_wr) begin
            ram[mem_a[15:0]] <= mem_dout;
            wv[mem_a[15:0]]  <= 1'b1;
        end
        mem_din <= rd(mem_a);
    end

    // Reference: little-endian gather of the bytes, then numeric sign/zero extension.
    function automatic logic [31:0] ref_result(input logic ls, input logic [3:0] t, input logic [31:0] a);
        longint v;
        int     n;
        logic [31:0] ai;
        if (ls && t[3]) return 32'h0;
        n = (!ls || t[1]) ? 4 : (t[0] ? 2 : 1);
        v = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v  = v + (longint'(rd(ai)) << (8 * i));
        end
        if (ls && !t[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Present one request in the current (IDLE) cycle and follow it to its pulse.
    task automatic run_txn(input string nm, input logic ls, input logic [3:0] t, input logic [31:0] a,
                           input logic [31:0] sv, input logic [31:0] exp_val, input int exp_lat);
        int          n, lat;
        logic        st;
        logic [31:0] got, ea;
        st = ls & t[3];
        n  = (!ls || t[1]) ? 4 : (t[0] ? 2 : 1);
        if (ls) begin
            ls_enable = 1'b1; addr = a; lsb_type = t; store_val = sv;
        end else begin
            if_enable = 1'b1; if_addr = a;
        end
        lat = 0;
        got = 32'hx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) begin ls_enable = 1'b0; if_enable = 1'b0; end
            if (k <= n) begin
                ea = a + 32'(k - 1);
                chk({nm, "_addr"}, mem_a, ea);
                chk({nm, "_wr"}, {31'b0, mem_wr}, {31'b0, st});
                if (st) chk({nm, "_dout"}, {24'b0, mem_dout}, {24'b0, sv[8*(k-1) +: 8]});
            end
            if (ls ? if_finished : ls_finished) chk({nm, "_stray_pulse"}, 32'd1, 32'd0);
            if (ls ? ls_finished : if_finished) begin
                lat = k;
                got = ls ? load_val : if_inst;
                break;
            end
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_value"}, got, exp_val);
    endtask

    typedef struct {
        string       nm;
        logic        ls;
        logic [3:0]  typ;
        logic [31:0] a;
        logic [31:0] sv;
        logic [31:0] exp_val;
        int          exp_lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [3:0]  codes [8];
        logic [31:0] prev, exp_w, wa [8];
        logic [7:0]  wd [8];
        logic        seen, rls;
        logic [3:0]  rt;
        logic [31:0] ra, rsv;
        int          lat, nwr, n;

        vecs[0]  = '{"lw_1000",  1'b1, LW,  32'h0000_1000, 32'h0,         32'h1234_5678, 6};
        vecs[1]  = '{"lb_20",    1'b1, LB,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 3};
        vecs[2]  = '{"lbu_20",   1'b1, LBU, 32'h0000_0020, 32'h0,         32'h0000_0080, 3};
        vecs[3]  = '{"sh_40",    1'b1, SH,  32'h0000_0040, 32'h0000_BEEF, 32'h0,         3};
        vecs[4]  = '{"lh_40",    1'b1, LH,  32'h0000_0040, 32'h0,         32'hFFFF_BEEF, 4};
        vecs[5]  = '{"lhu_40",   1'b1, LHU, 32'h0000_0040, 32'h0,         32'h0000_BEEF, 4};
        vecs[6]  = '{"if_1000",  1'b0, 4'h0, 32'h0000_1000, 32'h0,        32'h1234_5678, 6};
        vecs[7]  = '{"sw_50",    1'b1, SW,  32'h0000_0050, 32'hCAFE_F00D, 32'h0,         5};
        vecs[8]  = '{"lw_50",    1'b1, LW,  32'h0000_0050, 32'h0,         32'hCAFE_F00D, 6};
        vecs[9]  = '{"lw_wrap",  1'b1, LW,  32'hFFFF_FFFE, 32'h0,         32'h4433_2211, 6};
        vecs[10] = '{"sb_21",    1'b1, SB,  32'h0000_0021, 32'h1234_567F, 32'h0,         2};
        vecs[11] = '{"lh_20",    1'b1, LH,  32'h0000_0020, 32'h0,         32'h0000_7F80, 4};
        codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; ls_enable = 1'b0; if_addr = '0; addr = '0;
        store_val = '0; lsb_type = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_pulses", {30'b0, ls_finished, if_finished}, 32'h0);
        chk("rst_load_val", load_val, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Table vectors back-to-back: each next request is presented in the previous pulse cycle.
        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].nm, vecs[i].ls, vecs[i].typ, vecs[i].a, vecs[i].sv, vecs[i].exp_val, vecs[i].exp_lat);
        @(posedge clk_in); #1;

        // Simultaneous requests: LSB first, fetch accepted in the LSB pulse cycle.
        exp_w = ref_result(1'b0, 4'h0, 32'h20);
        ls_enable = 1'b1; addr = 32'h1000; lsb_type = LW; if_enable = 1'b1; if_addr = 32'h20;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) ls_enable = 1'b0;
            if (if_finished) chk("both_if_early", 32'd1, 32'd0);
            if (ls_finished) begin lat = k; chk("both_ls_val", load_val, 32'h1234_5678); break; end
        end
        chk("both_ls_lat", lat, 6);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) if_enable = 1'b0;
            if (if_finished) begin lat = k; chk("both_if_inst", if_inst, exp_w); break; end
        end
        chk("both_if_lat", lat, 6);
        @(posedge clk_in); #1;
        chk("if_pulse_one_cycle", {31'b0, if_finished}, 32'h0);
        chk("if_inst_hold", if_inst, exp_w);

        // Flush during a load: idle on the next cycle, no pulse, result unchanged.
        prev = load_val;
        ls_enable = 1'b1; addr = 32'h1000; lsb_type = LW;
        @(posedge clk_in); #1; ls_enable = 1'b0;
        @(posedge clk_in); #1; clear = 1'b1;
        @(posedge clk_in); #1; clear = 1'b0;
        chk("clr_ld_mem_a", mem_a, 32'h0);
        seen = ls_finished;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_in); #1;
            seen = seen | ls_finished;
        end
        chk("clr_ld_no_pulse", {31'b0, seen}, 32'h0);
        chk("clr_ld_load_val", load_val, prev);

        // Flush during a store: all bytes still written, pulse suppressed.
        ls_enable = 1'b1; addr = 32'h60; lsb_type = SW; store_val = 32'hA1B2_C3D4;
        nwr = 0; seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_in); #1;
            ls_enable = 1'b0;
            clear = (k == 2);
            if (mem_wr && nwr < 8) begin wa[nwr] = mem_a; wd[nwr] = mem_dout; nwr++; end
            seen = seen | ls_finished;
        end
        clear = 1'b0;
        chk("clr_st_nwr", nwr, 4);
        for (int i = 0; i < 4 && i < nwr; i++) begin
            chk("clr_st_addr", wa[i], 32'h60 + 32'(i));
            chk("clr_st_data", {24'b0, wd[i]}, {24'b0, store_val[8*i +: 8]});
        end
        chk("clr_st_no_pulse", {31'b0, seen}, 32'h0);
        chk("clr_st_ram", ref_result(1'b1, LW, 32'h60), 32'hA1B2_C3D4);

        // rdy_in low freezes the store and blocks the write strobe.
        ls_enable = 1'b1; addr = 32'h70; lsb_type = SH; store_val = 32'h0000_1234;
        @(posedge clk_in); #1; ls_enable = 1'b0; rdy_in = 1'b0; #1;
        chk("rdy_wr_blocked", {31'b0, mem_wr}, 32'h0);
        @(posedge clk_in); #1; rdy_in = 1'b1; #1;
        chk("rdy_wr0", {mem_a[23:0], mem_dout}, {24'h70, 8'h34});
        chk("rdy_wr0_en", {31'b0, mem_wr}, 32'h1);
        @(posedge clk_in); #1;
        chk("rdy_wr1", {mem_a[23:0], mem_dout}, {24'h71, 8'h12});
        @(posedge clk_in); #1;
        chk("rdy_pulse", {31'b0, ls_finished}, 32'h1);

        // IO-region store against a full IO write buffer.
        ls_enable = 1'b1; addr = 32'h0003_0000; lsb_type = SB; store_val = 32'h0000_005E;
        io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_in); #1; ls_enable = 1'b0; #1;
            chk("io_stall_no_wr", {31'b0, mem_wr}, 32'h0);
        end
        @(posedge clk_in); #1; io_buffer_full = 1'b0; #1;
        chk("io_stall_wr", {mem_wr, mem_a[30:0]}, {1'b1, 31'h0003_0000});
        chk("io_stall_dout", {24'b0, mem_dout}, 32'h5E);
        @(posedge clk_in); #1;
        chk("io_stall_pulse", {31'b0, ls_finished}, 32'h1);
`else
        @(posedge clk_in); #1; ls_enable = 1'b0; #1;
        chk("io_nostall_wr", {mem_wr, mem_a[30:0]}, {1'b1, 31'h0003_0000});
        @(posedge clk_in); #1;
        io_buffer_full = 1'b0;
        chk("io_nostall_pulse", {31'b0, ls_finished}, 32'h1);
`endif
        @(posedge clk_in); #1;

        // Randomized traffic over a small overlapping window.
        for (int i = 0; i < 40; i++) begin
            rls = ($urandom_range(0, 3) != 0);
            rt  = codes[$urandom_range(0, 7)];
            ra  = 32'h2000 + 32'($urandom_range(0, 31));
            rsv = $urandom;
            n   = (!rls || rt[1]) ? 4 : (rt[0] ? 2 : 1);
            run_txn("rnd", rls, rt, ra, rsv, ref_result(rls, rt, ra), (rls && rt[3]) ? n + 1 : n + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
